// File: rtl/ps2_key_event.sv
// Key-event decoder: pops PS/2 scancode bytes, folds E0/F0 prefixes into one
// event per key action, tracks Shift/Ctrl/CapsLock and counts fresh presses.
module ps2_key_event #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             rx_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic             shift_o,
  output logic             ctrl_o,
  output logic             caps_o,
  output logic [CNT_W-1:0] key_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  // {ext,code} of the held key; all-zero means nothing held (code 00 never decodes)
  logic [8:0]       held_q, held_d;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             rep_q, rep_d;
  logic             lshift_q, lshift_d;
  logic             rshift_q, rshift_d;
  logic             lctrl_q, lctrl_d;
  logic             rctrl_q, rctrl_d;
  logic             caps_q, caps_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       pop;
  logic       is_discard;
  logic       is_fake_shift;
  logic [8:0] key;
  logic       is_rep;

  // Bytes that never form or prefix an event: BAT/ack/resend/echo/errors/pause lead-in
  assign is_discard = (byte_q == 8'hAA) || (byte_q == 8'hFA) || (byte_q == 8'hFE) ||
                      (byte_q == 8'hEE) || (byte_q == 8'h00) || (byte_q == 8'hFF) ||
                      (byte_q == 8'hE1);
  assign is_fake_shift = ext_pend_q && ((byte_q == 8'h12) || (byte_q == 8'h59));
  assign key    = {ext_pend_q, byte_q};
  assign is_rep = !brk_pend_q && (key == held_q);

  // Next-state, byte classification and event/modifier bookkeeping
  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    held_d     = held_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    rep_d      = rep_q;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    lctrl_d    = lctrl_q;
    rctrl_d    = rctrl_q;
    caps_d     = caps_q;
    count_d    = count_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          pop     = 1'b1;
          byte_d  = rx_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_q == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else if (is_discard || is_fake_shift) begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else begin
          code_d     = byte_q;
          ext_d      = ext_pend_q;
          brk_d      = brk_pend_q;
          rep_d      = is_rep;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          state_d    = ST_EMIT;
          if (!brk_pend_q && !is_rep) begin
            held_d  = key;
            count_d = count_q + CNT_W'(1);
            if (byte_q == 8'h58) caps_d = ~caps_q;
          end else if (brk_pend_q && (key == held_q)) begin
            held_d = 9'd0;
          end
          if (byte_q == 8'h12) lshift_d = !brk_pend_q;
          if (byte_q == 8'h59) rshift_d = !brk_pend_q;
          if (byte_q == 8'h14) begin
            if (ext_pend_q) rctrl_d = !brk_pend_q;
            else            lctrl_d = !brk_pend_q;
          end
        end
      end
      ST_EMIT: begin
        if (evt_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any pending event, prefixes and held key
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q    <= ST_IDLE;
      byte_q     <= 8'h00;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      held_q     <= 9'd0;
      code_q     <= 8'h00;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      rep_q      <= 1'b0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      lctrl_q    <= 1'b0;
      rctrl_q    <= 1'b0;
      caps_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      held_q     <= held_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      rep_q      <= rep_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      lctrl_q    <= lctrl_d;
      rctrl_q    <= rctrl_d;
      caps_q     <= caps_d;
      count_q    <= count_d;
    end
  end

  // Pop strobe is masked while reset is held so the receiver never loses a byte
  assign rx_nextdata_n = ~(pop & ~clrn);
  assign evt_valid     = (state_q == ST_EMIT);
  assign evt_code      = code_q;
  assign evt_ext       = ext_q;
  assign evt_break     = brk_q;
  assign evt_repeat    = rep_q;
  assign shift_o       = lshift_q | rshift_q;
  assign ctrl_o        = lctrl_q | rctrl_q;
  assign caps_o        = caps_q;
  assign key_count     = count_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: FIFO-style receiver model, randomized byte traffic
// and a key-level reference model compared against the DUT every cycle.
module tb_ps2_key_event;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_repeat;
  logic       shift_o, ctrl_o, caps_o;
  logic [7:0] key_count;

  ps2_key_event #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_nextdata_n(rx_nextdata_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .evt_repeat(evt_repeat), .shift_o(shift_o), .ctrl_o(ctrl_o),
    .caps_o(caps_o), .key_count(key_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code; int ext; int brk; int rep;
    int shift; int ctrl; int caps; int cnt; int due;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        log_q[$];
  logic [7:0] fifo_q[$];

  // key-level model state
  int m_ext, m_brk, m_held_valid, m_held, m_caps, m_cnt;
  bit m_down[int];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int ready_mode = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h cycle=%0d", name, act, want, cyc);
    end
  endtask

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_held_valid = 0; m_held = 0;
    m_caps = 0; m_cnt = 0;
    m_down.delete();
    exp_q.delete();
  endfunction

  // Scancode rules at key level: prefixes accumulate, discards clear them,
  // any other byte finishes one key action.
  function automatic void model_byte(input int b, input int due);
    ev_t e;
    int key;
    if (b == 'hE0) m_ext = 1;
    else if (b == 'hF0) m_brk = 1;
    else if (b == 'hAA || b == 'hFA || b == 'hFE || b == 'hEE ||
             b == 'h00 || b == 'hFF || b == 'hE1) begin
      m_ext = 0; m_brk = 0;
    end else if (m_ext == 1 && (b == 'h12 || b == 'h59)) begin
      m_ext = 0; m_brk = 0;
    end else begin
      key   = m_ext * 256 + b;
      e.code = b; e.ext = m_ext; e.brk = m_brk;
      e.rep = (m_brk == 0 && m_held_valid == 1 && m_held == key) ? 1 : 0;
      if (m_brk == 0 && e.rep == 0) begin
        m_held = key; m_held_valid = 1;
        m_cnt = (m_cnt + 1) % 256;
        if (b == 'h58) m_caps = 1 - m_caps;
      end else if (m_brk == 1 && m_held_valid == 1 && m_held == key) begin
        m_held_valid = 0;
      end
      if (m_brk == 1) m_down.delete(key);
      else m_down[key] = 1'b1;
      e.shift = (m_down.exists('h012) || m_down.exists('h059)) ? 1 : 0;
      e.ctrl  = (m_down.exists('h014) || m_down.exists('h114)) ? 1 : 0;
      e.caps = m_caps; e.cnt = m_cnt; e.due = due;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // Receiver FIFO: head on rx_data, popped on the edge that sees nextdata_n low
  initial begin
    bit pop_f;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      pop_f = !rx_nextdata_n && !clrn;
      @(posedge clk);
      #1;
      if (pop_f && fifo_q.size() > 0) void'(fifo_q.pop_front());
      rx_ready = (fifo_q.size() > 0);
      rx_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Downstream ready: always, never, or random
  initial begin
    evt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       evt_ready = 1'b1;
        1:       evt_ready = 1'b0;
        default: evt_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Compare process: handshake rules, latency and event contents every cycle
  initial begin
    ev_t e;
    ev_t g;
    bit prev_pop, prev_valid;
    prev_pop = 0; prev_valid = 0;
    model_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (clrn) begin
        model_reset();
        prev_pop = 0; prev_valid = 0;
        chk("rst_flags", int'({rx_nextdata_n, evt_valid, evt_ext, evt_break,
                               evt_repeat, shift_o, ctrl_o, caps_o}), 'h80);
        chk("rst_code_cnt", int'({evt_code, key_count}), 0);
      end else begin
        if (!rx_nextdata_n) begin
          pops++;
          chk("pop_when_ready", int'(rx_ready), 1);
          chk("pop_not_single", int'(prev_pop), 0);
          model_byte(int'(rx_data), cyc + 2);
        end
        prev_pop = !rx_nextdata_n;
        if (evt_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 1, 0);
          end else begin
            e = exp_q[0];
            if (!prev_valid) chk("latency", cyc, e.due);
            chk("code", int'(evt_code), e.code);
            chk("ext", int'(evt_ext), e.ext);
            chk("brk", int'(evt_break), e.brk);
            chk("rep", int'(evt_repeat), e.rep);
            chk("shift", int'(shift_o), e.shift);
            chk("ctrl", int'(ctrl_o), e.ctrl);
            chk("caps", int'(caps_o), e.caps);
            chk("count", int'(key_count), e.cnt);
            if (evt_ready) begin
              g.code = int'(evt_code); g.ext = int'(evt_ext); g.brk = int'(evt_break);
              g.rep = int'(evt_repeat); g.shift = int'(shift_o); g.ctrl = int'(ctrl_o);
              g.caps = int'(caps_o); g.cnt = int'(key_count); g.due = cyc;
              log_q.push_back(g);
              void'(exp_q.pop_front());
              $display("evt code=%02h ext=%0d brk=%0d rep=%0d sh=%0d ct=%0d cp=%0d cnt=%0d",
                       g.code, g.ext, g.brk, g.rep, g.shift, g.ctrl, g.caps, g.cnt);
            end
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
          chk("event_missing", 0, 1);
          void'(exp_q.pop_front());
        end
        prev_valid = evt_valid;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    clrn = 1'b1;
    fifo_q.delete();
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    #2;
    clrn = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || evt_valid || exp_q.size() > 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("idle_timeout", 0, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s, p0, c;
    logic [7:0] pool [20];
    pool = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h58,
             8'h1C, 8'h1D, 8'h23, 8'h24, 8'h77, 8'hAA, 8'hFA, 8'hE1, 8'h00, 8'hFF};

    // 1: plain press/release
    do_reset();
    s = log_q.size(); p0 = pops;
    send(8'h1C); send(8'hF0); send(8'h1C);
    wait_idle();
    chk("t1_events", log_q.size() - s, 2);
    chk("t1_press", log_q[s].code * 16 + log_q[s].ext * 4 + log_q[s].brk * 2 + log_q[s].rep, 'h1C0);
    chk("t1_release", log_q[s+1].code * 16 + log_q[s+1].brk * 2, 'h1C2);
    chk("t1_count", int'(key_count), 1);
    chk("t1_pops", pops - p0, 3);

    // 2: R-ctrl press and release
    do_reset();
    s = log_q.size();
    send(8'hE0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
    wait_idle();
    chk("t2_press", log_q[s].code * 16 + log_q[s].ext * 4 + log_q[s].brk * 2, 'h144);
    chk("t2_ctrl_on", log_q[s].ctrl, 1);
    chk("t2_release", log_q[s+1].ext * 4 + log_q[s+1].brk * 2, 6);
    chk("t2_ctrl_off", log_q[s+1].ctrl, 0);
    chk("t2_count", int'(key_count), 1);

    // 3: typematic repeats
    do_reset();
    s = log_q.size();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    wait_idle();
    chk("t3_reps", log_q[s].rep * 4 + log_q[s+1].rep * 2 + log_q[s+2].rep, 3);
    chk("t3_break", log_q[s+3].brk, 1);
    chk("t3_count", int'(key_count), 1);

    // 4: CapsLock toggling, shift, fake shift
    do_reset();
    s = log_q.size();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
    send(8'h12); send(8'h1C);
    wait_idle();
    chk("t4_caps_on", log_q[s].caps, 1);
    chk("t4_caps_off", log_q[s+2].caps, 0);
    chk("t4_shift_1c", log_q[s+5].code * 2 + log_q[s+5].shift, 'h39);
    s = log_q.size();
    send(8'hE0); send(8'h12);
    wait_idle();
    chk("t4_fake_noevt", log_q.size() - s, 0);
    chk("t4_fake_shift", int'(shift_o), 1);

    // 5: backpressure
    do_reset();
    s = log_q.size();
    ready_mode = 1;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    repeat (20) @(negedge clk);
    chk("t5_held_valid", int'(evt_valid), 1);
    chk("t5_held_code", int'(evt_code), 'h15);
    chk("t5_fifo_left", fifo_q.size(), 3);
    ready_mode = 0;
    wait_idle();
    chk("t5_order", (log_q[s].code << 24) | (log_q[s+1].code << 16) |
                    (log_q[s+2].code << 8) | log_q[s+3].code, 'h151D242D);

    // random traffic with random backpressure and gaps
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 800; i++) begin
      send(pool[$urandom_range(0, 19)]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 29) == 0) repeat ($urandom_range(5, 40)) @(negedge clk);
    end
    ready_mode = 0;
    wait_idle();

    // 6: 256 distinct keys wrap the counter, then reset mid-prefix
    do_reset();
    ready_mode = 2;
    c = 1;
    for (int i = 0; i < 256; i++) begin
      int code, ext;
      if (i < 127) begin
        code = i + 1; ext = 0;
      end else begin
        while (c == 'h12 || c == 'h59) c++;
        code = c; ext = 1; c++;
      end
      if (ext == 1) send(8'hE0);
      send(8'(code));
      if (ext == 1) send(8'hE0);
      send(8'hF0);
      send(8'(code));
    end
    ready_mode = 0;
    wait_idle();
    chk("t6_wrap", int'(key_count), 0);
    send(8'hE0); send(8'hF0);
    wait_idle();
    do_reset();
    chk("t6_rst_flags", int'({evt_valid, shift_o, ctrl_o, caps_o}), 0);
    chk("t6_rst_count", int'(key_count), 0);
    s = log_q.size();
    send(8'h1C);
    wait_idle();
    chk("t6_plain", log_q[s].code * 16 + log_q[s].ext * 4 + log_q[s].brk * 2 + log_q[s].rep, 'h1C0);
    chk("t6_count", int'(key_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
